// File: rtl/mdu_ctrl_pkg.sv
// Shared op codes, FSM encodings and helpers for the E-stage multiply/divide unit.
// Optional accumulate ops (madd/maddu/msub/msubu) are enabled by MDU_MADD_EN.
package mdu_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;
    localparam logic [3:0] MD_MSUB  = 4'd11;
    localparam logic [3:0] MD_MSUBU = 4'd12;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_acc(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= MD_MADD) && (op <= MD_MSUBU);
`else
        return (op == 4'hF) && 1'b0;
`endif
    endfunction

    function automatic logic is_start(input logic [3:0] op);
        return ((op >= MD_MULT) && (op <= MD_DIVU)) || is_acc(op);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage multiply/divide bundle between the pipeline (master) and mdu_ctrl (slave).
// Carries operands, op code, stall request and HI/LO read-back.
interface mdu_ctrl_if;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        md_use_d;
    logic        busy;
    logic        start;
    logic        stall_md;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output md_op, rs_val, rt_val, flush, md_use_d,
        input  busy, start, stall_md, rd_data, hi, lo
    );

    modport slave (
        input  md_op, rs_val, rt_val, flush, md_use_d,
        output busy, start, stall_md, rd_data, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / divide / accumulate result for mdu_ctrl.
// Accumulate ops exist only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic        sgn;
    logic        sa;
    logic        sb;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] prod;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] qs;
    logic [31:0] rsg;

    // Division runs on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        sgn  = (op == MD_MULT) || (op == MD_DIV) ||
               (op == MD_MADD) || (op == MD_MSUB);
        a64  = sgn ? {{32{rs[31]}}, rs} : {32'b0, rs};
        b64  = sgn ? {{32{rt[31]}}, rt} : {32'b0, rt};
        prod = a64 * b64;
        sa   = sgn & rs[31];
        sb   = sgn & rt[31];
        ma   = sa ? -rs : rs;
        mb   = sb ? -rt : rt;
        q    = (mb == 32'b0) ? 32'b0 : ma / mb;
        r    = (mb == 32'b0) ? 32'b0 : ma % mb;
        qs   = (sa ^ sb) ? -q : q;
        rsg  = sa ? -r : r;
        res  = {hi, lo};
        case (op)
            MD_MULT, MD_MULTU: res = prod;
            MD_DIV, MD_DIVU: begin
                if (rt != 32'b0) res = {rsg, qs};
            end
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: res = {hi, lo} + prod;
            MD_MSUB, MD_MSUBU: res = {hi, lo} - prod;
`endif
            default: res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: HI/LO registers, busy countdown, stall request.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    mdu_ctrl_if.slave md
);

    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic [63:0] res;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        idle;

    assign idle        = (state == ST_IDLE);
    assign md.start    = is_start(md.md_op) & idle & ~md.flush;
    assign md.busy     = (state == ST_BUSY);
    assign md.stall_md = md.md_use_d & (md.start | md.busy);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

    always_comb begin
        md.rd_data = 32'b0;
        if (md.md_op == MD_MFHI) md.rd_data = hi_q;
        if (md.md_op == MD_MFLO) md.rd_data = lo_q;
    end

    mdu_arith u_arith (
        .op  (md.md_op),
        .rs  (md.rs_val),
        .rt  (md.rt_val),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (res)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            pend  <= 64'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (md.start) begin
                        state <= ST_BUSY;
                        cnt   <= is_div(md.md_op) ? DC : MC;
                        pend  <= res;
                    end else if (!md.flush) begin
                        if (md.md_op == MD_MTHI) hi_q <= md.rs_val;
                        if (md.md_op == MD_MTLO) lo_q <= md.rs_val;
                    end
                end
                ST_BUSY: begin
                    // Flush does not stop a running op: its issuer already committed.
                    if (cnt == 4'd1) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                        hi_q  <= pend[63:32];
                        lo_q  <= pend[31:0];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: per-cycle behavioural model plus directed literals.
// Build with or without MDU_MADD_EN.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mdu_ctrl_if mif();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (mif)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 1 && op <= 4) || (op >= 9 && op <= 12);
`else
        return (op >= 1 && op <= 4);
`endif
    endfunction

    function automatic logic [63:0] model_res(input logic [3:0] op,
        input logic [31:0] rs, input logic [31:0] rt,
        input logic [31:0] h, input logic [31:0] l);
        longint sa, sb, ps;
        logic [63:0] pu;
        int a, b;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ps = sa * sb;
        pu = {32'b0, rs} * {32'b0, rt};
        a = rs;
        b = rt;
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (rt == 0) return {h, l};
                if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(a % b), 32'(a / b)};
            end
            4'd4: begin
                if (rt == 0) return {h, l};
                return {rs % rt, rs / rt};
            end
            4'd9:  return {h, l} + ps;
            4'd10: return {h, l} + pu;
            4'd11: return {h, l} - ps;
            4'd12: return {h, l} - pu;
            default: return {h, l};
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int m_left;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_pend;
        end else if (!mif.flush) begin
            if (legal(mif.md_op)) begin
                m_pend = model_res(mif.md_op, mif.rs_val, mif.rt_val, m_hi, m_lo);
                m_left = (mif.md_op == 3 || mif.md_op == 4) ? DC : MC;
            end else if (mif.md_op == 7) m_hi = mif.rs_val;
            else if (mif.md_op == 8) m_lo = mif.rs_val;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            logic eb, es;
            logic [31:0] erd;
            eb = (m_left != 0);
            es = legal(mif.md_op) && !eb && !mif.flush;
            erd = (mif.md_op == 5) ? m_hi : (mif.md_op == 6) ? m_lo : 32'h0;
            chk("m_busy", mif.busy, eb);
            chk("m_start", mif.start, es);
            chk("m_stall", mif.stall_md, mif.md_use_d & (es | eb));
            chk("m_hi", mif.hi, m_hi);
            chk("m_lo", mif.lo, m_lo);
            chk("m_rd", mif.rd_data, erd);
            if (mif.busy && !mif.flush)
                chk("op_while_busy", legal(mif.md_op) || mif.md_op == 7 || mif.md_op == 8, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs,
        input logic [31:0] rt, input logic fl = 1'b0);
        mif.md_op = op;
        mif.rs_val = rs;
        mif.rt_val = rt;
        mif.flush = fl;
    endtask

    task automatic run_busy(output int n);
        n = 0;
        while (mif.busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] rs,
        input logic [31:0] rt, output int n);
        drive(op, rs, rt);
        step();
        drive(0, 0, 0);
        run_busy(n);
    endtask

    logic [3:0]  t_op [6] = '{3, 3, 3, 4, 1, 2};
    logic [31:0] t_rs [6] = '{7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF,
                              32'h80000000, 32'h80000000};
    logic [31:0] t_rt [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 16,
                              32'h80000000, 32'h80000000};

    initial begin
        int n;
        drive(0, 0, 0);
        mif.md_use_d = 1'b0;
        #12;
        chk("rst_busy", mif.busy, 0);
        chk("rst_hi", mif.hi, 0);
        chk("rst_lo", mif.lo, 0);
        #10 reset_n = 1'b1;
        step();

        drive(1, 32'hFFFFFFFE, 3);
        #1 chk("mult_start", mif.start, 1);
        step();
        drive(0, 0, 0);
        run_busy(n);
        chk("mult_cycles", n, MC);
        chk("mult_hi", mif.hi, 32'hFFFFFFFF);
        chk("mult_lo", mif.lo, 32'hFFFFFFFA);

        do_op(2, 32'hFFFFFFFE, 3, n);
        chk("multu_hi", mif.hi, 32'h00000002);
        chk("multu_lo", mif.lo, 32'hFFFFFFFA);

        do_op(3, 32'hFFFFFFF9, 2, n);
        chk("div_cycles", n, DC);
        chk("div_lo", mif.lo, 32'hFFFFFFFD);
        chk("div_hi", mif.hi, 32'hFFFFFFFF);

        do_op(4, 7, 0, n);
        chk("divz_cycles", n, DC);
        chk("divz_lo", mif.lo, 32'hFFFFFFFD);
        chk("divz_hi", mif.hi, 32'hFFFFFFFF);

        do_op(3, 32'h80000000, 32'hFFFFFFFF, n);
        chk("ovf_lo", mif.lo, 32'h80000000);
        chk("ovf_hi", mif.hi, 0);

        for (int i = 0; i < 6; i++) begin
            do_op(t_op[i], t_rs[i], t_rt[i], n);
            if (i == 0) begin
                chk("tab_div_lo", mif.lo, 32'hFFFFFFFD);
                chk("tab_div_hi", mif.hi, 1);
            end
        end

        mif.md_use_d = 1'b1;
        drive(1, 3, 5);
        #1 chk("stall_issue", mif.stall_md, 1);
        step();
        drive(0, 0, 0);
        n = 0;
        while (mif.busy === 1'b1 && n < 40) begin
            chk("stall_busy", mif.stall_md, 1);
            n++;
            step();
        end
        chk("stall_n", n, MC);
        chk("stall_fall", mif.stall_md, 0);
        drive(6, 0, 0);
        #1 chk("mflo", mif.rd_data, 15);
        drive(5, 0, 0);
        #1 chk("mfhi", mif.rd_data, 0);
        mif.md_use_d = 1'b0;
        step();

        drive(7, 32'h12345678, 0, 1'b1);
        step();
        chk("mthi_flush", mif.hi, 0);
        drive(7, 32'h12345678, 0);
        step();
        chk("mthi", mif.hi, 32'h12345678);
        drive(1, 2, 2, 1'b1);
        #1 chk("flush_start", mif.start, 0);
        step();
        chk("flush_busy", mif.busy, 0);
        drive(0, 0, 0);
        step();

        drive(3, 100, 7);
        step();
        drive(0, 0, 0);
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", mif.busy, 0);
        chk("arst_hi", mif.hi, 0);
        chk("arst_lo", mif.lo, 0);
        #2 reset_n = 1'b1;
        step();
        do_op(1, 6, 7, n);
        chk("post_rst_n", n, MC);
        chk("post_rst_lo", mif.lo, 42);
        chk("post_rst_hi", mif.hi, 0);

        drive(7, 0, 0);
        step();
        drive(8, 32'hFFFFFFFF, 0);
        step();
        drive(10, 1, 1);
`ifdef MDU_MADD_EN
        #1 chk("maddu_start", mif.start, 1);
        step();
        drive(0, 0, 0);
        run_busy(n);
        chk("maddu_n", n, MC);
        chk("maddu_hi", mif.hi, 1);
        chk("maddu_lo", mif.lo, 0);
        do_op(11, 2, 3, n);
        chk("msub_hi", mif.hi, 0);
        chk("msub_lo", mif.lo, 32'hFFFFFFFA);
`else
        #1 chk("maddu_start", mif.start, 0);
        step();
        drive(0, 0, 0);
        chk("maddu_busy", mif.busy, 0);
        chk("maddu_hi", mif.hi, 0);
        chk("maddu_lo", mif.lo, 32'hFFFFFFFF);
`endif
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
